mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 162 ++++++++++++++++
 tb/tb_mem_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Brief    : Pipeline MEM stage. Issues one data-memory request at a time,
//            stalls the front of the pipeline until the ack arrives, aborts
//            with a sticky bus error after TIMEOUT cycles, and loads MEM/WB.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic        ex_reg_write,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic        ex_reg_store,
   input  logic [15:0] ex_alu_result,
   input  logic [15:0] ex_store_data,
   input  logic [15:0] ex_rd,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [15:0] dmem_addr,
   output logic [15:0] dmem_wdata,
   input  logic [15:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        stall,
   output logic        wb_valid,
   output logic        wb_reg_write,
   output logic [15:0] wb_rd,
   output logic [15:0] wb_data,
   output logic        bus_err
);

   // Counter value seen in the last BUSY cycle before an abort: the counter
   // starts at 0 on entry, so the abort lands at the end of BUSY cycle TIMEOUT.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [7:0]  wait_cnt;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        req_we;
   logic        mem_op;
   logic        done;
   logic        timeout_hit;

   assign mem_op = ex_valid & (ex_mem_read | ex_mem_write);

   // Next-state and memory-interface outputs; reset forces req/stall low.
   always_comb begin
      state_next  = state;
      stall       = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      dmem_addr   = ex_alu_result;
      dmem_wdata  = ex_store_data;
      done        = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (mem_op) begin
               stall      = 1'b1;
               dmem_req   = 1'b1;
               // A simultaneous read+write is treated as a write.
               dmem_we    = ex_mem_write;
               state_next = BUSY;
            end
         end
         BUSY: begin
            dmem_req   = 1'b1;
            dmem_we    = req_we;
            dmem_addr  = req_addr;
            dmem_wdata = req_wdata;
            stall      = ~dmem_ack;
            // Ack wins over a timeout occurring on the same edge.
            if (dmem_ack) begin
               done       = 1'b1;
               state_next = IDLE;
            end else if (wait_cnt >= TIMEOUT_LAST) begin
               timeout_hit = 1'b1;
               state_next  = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (reset) begin
         stall    = 1'b0;
         dmem_req = 1'b0;
      end
   end

   // State register, saturating wait counter, request latch and sticky error.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         wait_cnt  <= 8'd0;
         req_addr  <= 16'h0000;
         req_wdata <= 16'h0000;
         req_we    <= 1'b0;
         bus_err   <= 1'b0;
      end else begin
         state <= state_next;
         if (state == IDLE) begin
            wait_cnt <= 8'd0;
            if (mem_op) begin
               req_addr  <= ex_alu_result;
               req_wdata <= ex_store_data;
               req_we    <= ex_mem_write;
            end
         end else if (done || timeout_hit) begin
            wait_cnt <= 8'd0;
         end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
         if (timeout_hit) begin
            bus_err <= 1'b1;
         end
      end
   end

   // MEM/WB register: completed ops and non-memory ops load, stalls load bubbles.
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_valid     <= 1'b0;
         wb_reg_write <= 1'b0;
         wb_rd        <= 16'h0000;
         wb_data      <= 16'h0000;
      end else if (state == BUSY) begin
         if (done) begin
            wb_valid     <= 1'b1;
            wb_reg_write <= ex_reg_write;
            wb_rd        <= ex_rd;
            wb_data      <= ex_reg_store ? dmem_rdata : ex_alu_result;
         end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
         end
      end else if (mem_op) begin
         wb_valid     <= 1'b0;
         wb_reg_write <= 1'b0;
      end else if (ex_valid) begin
         wb_valid     <= 1'b1;
         wb_reg_write <= ex_reg_write;
         wb_rd        <= ex_rd;
         wb_data      <= ex_alu_result;
      end else begin
         wb_valid <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Directed self-checking bench for mem_stage (TIMEOUT = 4) with a
//            write-back scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_reg_store;
   logic [15:0] ex_alu_result, ex_store_data, ex_rd;
   logic        dmem_req, dmem_we;
   logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        dmem_ack;
   logic        stall, wb_valid, wb_reg_write, bus_err;
   logic [15:0] wb_rd, wb_data;

   typedef struct packed {
      logic        rw;
      logic [15:0] rd;
      logic [15:0] data;
   } wb_t;

   wb_t sbq[$];
   int  n_total = 0;
   int  n_pass  = 0;
   int  n_stall;

   mem_stage #(.TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_reg_store(ex_reg_store), .ex_alu_result(ex_alu_result),
      .ex_store_data(ex_store_data), .ex_rd(ex_rd),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .stall(stall), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
      .wb_rd(wb_rd), .wb_data(wb_data), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Advance one clock edge, then compare any write-back against the scoreboard.
   task automatic cyc();
      wb_t e;
      @(posedge clk);
      #1;
      if (wb_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("wb_unexpected", 32'(sbq.size()), 32'd1);
         end else begin
            e = sbq.pop_front();
            chk("wb_rd", {16'h0, wb_rd}, {16'h0, e.rd});
            chk("wb_data", {16'h0, wb_data}, {16'h0, e.data});
            chk("wb_reg_write", {31'h0, wb_reg_write}, {31'h0, e.rw});
         end
      end
   endtask

   task automatic idle_in();
      ex_valid = 1'b0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
      ex_mem_write = 1'b0; ex_reg_store = 1'b0; dmem_ack = 1'b0;
   endtask

   task automatic drive(input logic rw, input logic rd_en, input logic wr_en,
                        input logic rs, input logic [15:0] alu,
                        input logic [15:0] sd, input logic [15:0] rd);
      ex_valid = 1'b1; ex_reg_write = rw; ex_mem_read = rd_en;
      ex_mem_write = wr_en; ex_reg_store = rs; ex_alu_result = alu;
      ex_store_data = sd; ex_rd = rd;
   endtask

   initial begin
      reset = 1'b1; dmem_rdata = 16'h0000;
      ex_alu_result = 16'h0; ex_store_data = 16'h0; ex_rd = 16'h0;
      idle_in();
      // Reset: a pending memory op must not raise req/stall.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0040, 16'h0, 16'd3);
      #1;
      chk("rst_req", {31'h0, dmem_req}, 32'd0);
      chk("rst_stall", {31'h0, stall}, 32'd0);
      cyc(); cyc();
      idle_in();
      reset = 1'b0;
      cyc();
      chk("rst_wb_valid", {31'h0, wb_valid}, 32'd0);
      chk("rst_bus_err", {31'h0, bus_err}, 32'd0);

      // ALU op: one-cycle pass-through, no request, no stall.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h00FF, 16'h0, 16'd5);
      sbq.push_back('{rw: 1'b1, rd: 16'd5, data: 16'h00FF});
      #1;
      chk("alu_req", {31'h0, dmem_req}, 32'd0);
      chk("alu_stall", {31'h0, stall}, 32'd0);
      cyc();
      chk("alu_wb_valid", {31'h0, wb_valid}, 32'd1);
      idle_in();

      // Load: two BUSY cycles without ack, ack on the third.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0040, 16'h0, 16'd3);
      sbq.push_back('{rw: 1'b1, rd: 16'd3, data: 16'hBEEF});
      n_stall = 0;
      #1;
      chk("ld_we", {31'h0, dmem_we}, 32'd0);
      chk("ld_addr", {16'h0, dmem_addr}, 32'h0040);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin dmem_ack = 1'b1; dmem_rdata = 16'hBEEF; #1; end
         if (stall === 1'b1) n_stall++;
         chk("ld_req", {31'h0, dmem_req}, 32'd1);
         cyc();
         if (i == 0) chk("ld_bubble", {31'h0, wb_valid}, 32'd0);
      end
      chk("ld_stall_cycles", 32'(n_stall), 32'd3);
      chk("ld_wb_valid", {31'h0, wb_valid}, 32'd1);
      idle_in();

      // Store: ack in the first BUSY cycle; latched fields held.
      drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h1234, 16'd7);
      sbq.push_back('{rw: 1'b0, rd: 16'd7, data: 16'h0010});
      #1;
      chk("st_we", {31'h0, dmem_we}, 32'd1);
      cyc();
      dmem_ack = 1'b1; dmem_rdata = 16'h5555;
      #1;
      chk("st_busy_we", {31'h0, dmem_we}, 32'd1);
      chk("st_busy_addr", {16'h0, dmem_addr}, 32'h0010);
      chk("st_busy_wdata", {16'h0, dmem_wdata}, 32'h1234);
      chk("st_ack_stall", {31'h0, stall}, 32'd0);
      cyc();
      chk("st_wb_valid", {31'h0, wb_valid}, 32'd1);
      idle_in();

      // Read and write both set: treated as a write.
      drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0020, 16'hA5A5, 16'd9);
      sbq.push_back('{rw: 1'b1, rd: 16'd9, data: 16'h0020});
      #1;
      chk("rw_we", {31'h0, dmem_we}, 32'd1);
      cyc();
      dmem_ack = 1'b1;
      cyc();
      idle_in();

      // Stray ack in IDLE: no request, no state change.
      dmem_ack = 1'b1; dmem_rdata = 16'hDEAD;
      #1;
      chk("stray_req", {31'h0, dmem_req}, 32'd0);
      cyc();
      idle_in();
      #1;
      chk("stray_idle_req", {31'h0, dmem_req}, 32'd0);
      chk("stray_wb_valid", {31'h0, wb_valid}, 32'd0);

      // Timeout: load with no ack, abort after 4 BUSY cycles.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0080, 16'h0, 16'd4);
      cyc(); cyc(); cyc(); cyc();
      #1;
      chk("to_busy4_stall", {31'h0, stall}, 32'd1);
      chk("to_busy4_err", {31'h0, bus_err}, 32'd0);
      cyc();
      chk("to_bus_err", {31'h0, bus_err}, 32'd1);
      chk("to_wb_bubble", {31'h0, wb_valid}, 32'd0);
      idle_in();
      #1;
      chk("to_stall_rel", {31'h0, stall}, 32'd0);
      chk("to_idle_req", {31'h0, dmem_req}, 32'd0);
      cyc();
      chk("to_sticky", {31'h0, bus_err}, 32'd1);

      // Reset clears the sticky error.
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("clr_bus_err", {31'h0, bus_err}, 32'd0);

      // Ack on the timeout cycle: normal completion.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0090, 16'h0, 16'd6);
      sbq.push_back('{rw: 1'b1, rd: 16'd6, data: 16'hC0DE});
      cyc(); cyc(); cyc(); cyc();
      dmem_ack = 1'b1; dmem_rdata = 16'hC0DE;
      cyc();
      chk("tack_bus_err", {31'h0, bus_err}, 32'd0);
      chk("tack_wb_valid", {31'h0, wb_valid}, 32'd1);
      idle_in();

      // Reset in BUSY together with ack: ack is discarded.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h00A0, 16'h0, 16'd2);
      cyc(); cyc();
      reset = 1'b1; dmem_ack = 1'b1; dmem_rdata = 16'h7777;
      #1;
      chk("mrst_req", {31'h0, dmem_req}, 32'd0);
      cyc();
      chk("mrst_wb_valid", {31'h0, wb_valid}, 32'd0);
      chk("mrst_wb_rd", {16'h0, wb_rd}, 32'd0);
      chk("mrst_wb_data", {16'h0, wb_data}, 32'd0);
      chk("mrst_bus_err", {31'h0, bus_err}, 32'd0);
      reset = 1'b0;
      idle_in();
      #1;
      chk("mrst_idle_req", {31'h0, dmem_req}, 32'd0);
      cyc();

      // Following load completes normally.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h00B0, 16'h0, 16'd8);
      sbq.push_back('{rw: 1'b1, rd: 16'd8, data: 16'h4321});
      cyc();
      dmem_ack = 1'b1; dmem_rdata = 16'h4321;
      cyc();
      chk("post_wb_valid", {31'h0, wb_valid}, 32'd1);
      idle_in();
      cyc();

      chk("sb_empty", 32'(sbq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
